// File: rtl/clk_period_monitor_pkg.sv
// Shared definitions for the clock period monitor: FSM state encoding and
// the default counter width.
package clk_period_monitor_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW
    } state_e;

endpackage

// File: rtl/clk_period_monitor_sync_edge_det.sv
// Brings an asynchronous input into the clk domain and emits registered
// one-cycle rise/fall pulses from the synchronized level.
module clk_period_monitor_sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   rise_q;
    logic                   fall_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & dly_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures period and high time of an asynchronous strobe in clk cycles,
// checks the period against EXP_PERIOD +/- TOL and flags a stalled input.
module clk_period_monitor
    import clk_period_monitor_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int EXP_PERIOD  = 10,
    parameter int TOL         = 1,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             in_tol,
    output logic             timeout_err,
    output logic             busy
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    logic rise, fall;

    clk_period_monitor_sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .sig_i (sig_in),
        .rise_o(rise),
        .fall_o(fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [TO_W-1:0]  since_q, since_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             in_tol_q, in_tol_d;
    logic             meas_valid_q, meas_valid_d;
    logic             timeout_err_q, timeout_err_d;

    logic [CNT_W-1:0] cnt_inc, diff;
    logic             tol_ok;

    // A saturated count means the true period is unknown, so it is never in tolerance.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign diff    = (cnt_q >= EXP_C) ? cnt_q - EXP_C : EXP_C - cnt_q;
    assign tol_ok  = (cnt_q != CNT_MAX) && (diff <= TOL_C);

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_lat_d      = hi_lat_q;
        since_d       = since_q;
        period_d      = period_q;
        high_time_d   = high_time_q;
        in_tol_d      = in_tol_q;
        meas_valid_d  = 1'b0;
        timeout_err_d = timeout_err_q;

        if (!en) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            hi_lat_d      = '0;
            since_d       = '0;
            timeout_err_d = 1'b0;
        end else begin
            since_d = (rise || fall) ? '0 : since_q + TO_W'(1);
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                    since_d = '0;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        hi_lat_d = cnt_q;
                        state_d  = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_d     = cnt_q;
                        high_time_d  = hi_lat_q;
                        in_tol_d     = tol_ok;
                        meas_valid_d = 1'b1;
                        cnt_d        = CNT_W'(1);
                        state_d      = ST_HIGH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (state_q != ST_IDLE && !(rise || fall) && since_q == TO_LAST) begin
                timeout_err_d = 1'b1;
                state_d       = ST_ARM;
                cnt_d         = '0;
                since_d       = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            hi_lat_q      <= '0;
            since_q       <= '0;
            period_q      <= '0;
            high_time_q   <= '0;
            in_tol_q      <= 1'b0;
            meas_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_lat_q      <= hi_lat_d;
            since_q       <= since_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            in_tol_q      <= in_tol_d;
            meas_valid_q  <= meas_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign meas_valid  = meas_valid_q;
    assign period      = period_q;
    assign high_time   = high_time_q;
    assign in_tol      = in_tol_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
